// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard detection for the ID stage.
// Optional build macro FWD_PERF_CNT_EN adds perf_stall / perf_fwd cycle counters.
//
// state | meaning
// RUN   | no stall in progress, stall_cnt reads 0
// STALL | ID held for a pending load result, stall_cnt counts held cycles
module fwd_hazard_unit #(
  parameter int XLEN = 32,
  parameter int NSTG = 3,
  parameter int AW   = 5
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst_n,
  input  logic                 id_valid,
  input  logic [AW-1:0]        id_rs1,
  input  logic [AW-1:0]        id_rs2,
  input  logic                 id_rs1_used,
  input  logic                 id_rs2_used,
  input  logic [AW-1:0]        id_rd,
  input  logic                 id_we,
  input  logic                 id_is_load,
  input  logic                 flush,
  input  logic [NSTG*XLEN-1:0] stg_wd,
  input  logic [NSTG-1:0]      stg_wd_ok,
  output logic                 fwd_en_rs1,
  output logic                 fwd_en_rs2,
  output logic [XLEN-1:0]      fwd_rs1,
  output logic [XLEN-1:0]      fwd_rs2,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic [1:0]           stall_cnt
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall,
  output logic [31:0]          perf_fwd
`endif
);

  typedef enum logic {RUN, STALL} state_t;

  state_t          state;
  logic [1:0]      cntQ;
  logic [AW-1:0]   shRd [NSTG];
  logic [NSTG-1:0] shWe;
  logic [NSTG-1:0] shLoad;

  logic            hit1, hit2, ok1, ok2, haz1, haz2, hazard;
  logic [XLEN-1:0] data1, data2;
  logic [1:0]      cntBase;

  // Load flags mirror the pipeline for observability; readiness comes from stg_wd_ok.
  logic unusedLoad;
  assign unusedLoad = ^shLoad;

  // Walk oldest to youngest so the youngest matching stage wins.
  always_comb begin
    hit1  = 1'b0;
    ok1   = 1'b0;
    data1 = '0;
    hit2  = 1'b0;
    ok2   = 1'b0;
    data2 = '0;
    for (int k = NSTG - 1; k >= 0; k--) begin
      if (id_valid && id_rs1_used && (id_rs1 != '0) && shWe[k] && (shRd[k] == id_rs1)) begin
        hit1  = 1'b1;
        ok1   = stg_wd_ok[k];
        data1 = stg_wd[k*XLEN +: XLEN];
      end
      if (id_valid && id_rs2_used && (id_rs2 != '0) && shWe[k] && (shRd[k] == id_rs2)) begin
        hit2  = 1'b1;
        ok2   = stg_wd_ok[k];
        data2 = stg_wd[k*XLEN +: XLEN];
      end
    end
  end

  assign haz1   = hit1 & ~ok1;
  assign haz2   = hit2 & ~ok2;
  assign hazard = haz1 | haz2;

  assign fwd_en_rs1 = cpu_rst_n & hit1 & ok1;
  assign fwd_en_rs2 = cpu_rst_n & hit2 & ok2;
  assign fwd_rs1    = fwd_en_rs1 ? data1 : '0;
  assign fwd_rs2    = fwd_en_rs2 ? data2 : '0;

  // Reset gating keeps the outputs quiet while rst is held, even with flush high.
  assign stall_id  = cpu_rst_n & hazard & ~flush;
  assign bubble_ex = cpu_rst_n & (hazard | flush);

  assign cntBase   = (state == STALL) ? cntQ : 2'd0;
  assign stall_cnt = !stall_id ? 2'd0 : ((cntBase == 2'd3) ? 2'd3 : cntBase + 2'd1);

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state <= RUN;
      cntQ  <= 2'd0;
    end else if (flush) begin
      state <= RUN;
      cntQ  <= 2'd0;
    end else if (stall_id) begin
      state <= STALL;
      cntQ  <= stall_cnt;
    end else begin
      state <= RUN;
      cntQ  <= 2'd0;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int k = 0; k < NSTG; k++) shRd[k] <= '0;
      shWe   <= '0;
      shLoad <= '0;
    end else begin
      for (int k = NSTG - 1; k > 0; k--) begin
        shRd[k]   <= shRd[k-1];
        shWe[k]   <= shWe[k-1];
        shLoad[k] <= shLoad[k-1];
      end
      if (stall_id || flush) begin
        shRd[0]   <= '0;
        shWe[0]   <= 1'b0;
        shLoad[0] <= 1'b0;
      end else begin
        shRd[0]   <= id_rd;
        shWe[0]   <= id_we & id_valid;
        shLoad[0] <= id_is_load;
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      perf_stall <= '0;
      perf_fwd   <= '0;
    end else begin
      perf_stall <= perf_stall + 32'(stall_id);
      perf_fwd   <= perf_fwd + 32'(fwd_en_rs1 | fwd_en_rs2);
    end
  end
`endif

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter XLEN, default 32: width of register data.
REQ-002 Parameter NSTG, default 3: number of tracked in-flight stages; stage 0 = EX, 1 = MEM, 2 = WB; legal range 1..4.
REQ-003 Parameter AW, default 5: register address width.
REQ-004 cpu_clk  in  1  single clock; all state updates on rising edge.
REQ-005 cpu_rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 id_valid  in  1  an instruction occupies ID this cycle.
REQ-007 id_rs1, id_rs2  in  AW each  source register addresses in ID.
REQ-008 id_rs1_used, id_rs2_used  in  1 each  the source is actually read.
REQ-009 id_rd  in  AW  destination register of the ID instruction.
REQ-010 id_we  in  1  the ID instruction writes id_rd.
REQ-011 id_is_load  in  1  the ID instruction is a load.
REQ-012 flush  in  1  taken branch or jump; kills the ID instruction.
REQ-013 stg_wd  in  NSTG*XLEN  write-back data per stage; stage k occupies bits [k*XLEN +: XLEN].
REQ-014 stg_wd_ok  in  NSTG  data of stage k is final (0 = load data not yet returned).
REQ-015 fwd_en_rs1, fwd_en_rs2  out  1 each  the forwarded value replaces the register-file value.
REQ-016 fwd_rs1, fwd_rs2  out  XLEN each  forwarded data; 0 when the matching enable is low.
REQ-017 stall_id  out  1  hold PC and IF/ID this cycle.
REQ-018 bubble_ex  out  1  insert a NOP into ID/EX this cycle.
REQ-019 stall_cnt  out  2  consecutive stall cycles of the current stall, saturating at 3.

Function
REQ-020 An internal shadow shift register holds {rd, we, is_load} for stages 0..NSTG-1 and mirrors the pipeline.
REQ-021 Each cycle without stall or flush: stage 0 loads {id_rd, id_we & id_valid, id_is_load}, and stage k loads stage k-1.
REQ-022 When stall_id or flush is high, stage 0 loads a bubble (we = 0); the older stages still shift.
REQ-023 Stage k matches source s when we[k]=1, rd[k]==s, s!=0, and the corresponding id_rsX_used=1.
REQ-024 Per source, the youngest (lowest k) matching stage is selected; older matches are ignored.
REQ-025 When the selected stage has stg_wd_ok[k]=1: fwd_en=1 and fwd data = stg_wd slice k, combinationally in the same cycle.
REQ-026 When the selected stage has stg_wd_ok[k]=0: hazard; the block raises stall_id=1 and bubble_ex=1 for that source, and that source's fwd_en=0.
REQ-027 The FSM has two states, RUN and STALL; RUN->STALL on hazard with id_valid=1; STALL->RUN on the first cycle without hazard.
REQ-028 stall_cnt is 0 in RUN, increments on each STALL cycle, and saturates at 3.
REQ-029 Flush has priority over stall: when flush=1, stall_id=0, bubble_ex=1, the FSM goes to RUN, and stall_cnt goes to 0.
REQ-030 With id_valid=0, no forwarding or stall is raised (all fwd_en=0, stall_id=0).
REQ-031 Register x0 is never forwarded and never causes a stall.

Reset
REQ-032 cpu_rst_n=0 immediately clears all shadow entries (we=0, rd=0, is_load=0), sets the FSM to RUN, and sets stall_cnt=0.
REQ-033 During reset, stall_id=0, bubble_ex=0, and both fwd_en=0; reset asserted mid-stall drops stall_id in the same cycle.

Configuration
REQ-034 Macro FWD_PERF_CNT_EN defined: adds outputs perf_stall (32-bit) and perf_fwd (32-bit).
REQ-035 perf_stall counts stall_id cycles and perf_fwd counts cycles with any fwd_en high; both wrap at 2^32 and reset to 0.
REQ-036 Macro FWD_PERF_CNT_EN undefined: the counters and their ports are absent; all other behaviour is identical.

Verification
REQ-037 ALU x5 in EX with stg_wd_ok[0]=1 and wd=0x1234, ID reads rs1=x5 -> fwd_en_rs1=1, fwd_rs1=0x1234, stall_id=0.
REQ-038 Load x6 in EX with stg_wd_ok[0]=0, ID reads rs2=x6 -> stall_id=1, bubble_ex=1, stall_cnt=1; next cycle load in MEM with ok=1 and wd=0xBEEF -> fwd_rs2=0xBEEF, stall_id=0.
REQ-039 x7 written in both EX (0xA) and WB (0xB), ID reads x7 -> fwd_rs1=0xA.
REQ-040 ID reads x0 while EX writes x0 -> fwd_en=0, stall_id=0.
REQ-041 Hazard present and flush=1 in the same cycle -> stall_id=0, bubble_ex=1, FSM=RUN; shadow stage 0 is a bubble next cycle.
REQ-042 cpu_rst_n pulsed low during STALL -> outputs clear immediately; after release no stale forward occurs.
